// File: rtl/fifo_rd_arb_pkg.sv
// Shared types and helpers for the async FIFO read-side arbiter.
package fifo_rd_arb_pkg;

  localparam int MAX_REQ = 8;

  typedef enum logic {
    IDLE,
    SERVE
  } state_t;

  function automatic logic [31:0] bin2gray(input logic [31:0] b);
    return b ^ (b >> 1);
  endfunction

endpackage

// File: rtl/fifo_rd_arbiter_rr_pick.sv
// Combinational round-robin picker: first set req bit above last_owner, wrapping.
module rr_pick #(
  parameter int num_Req = 4,
  localparam int IW = $clog2(num_Req)
) (
  input  logic [num_Req-1:0] req,
  input  logic [IW-1:0]      last_owner,
  output logic [IW-1:0]      owner,
  output logic               valid
);

  int            idx;
  logic [IW-1:0] idx_w;

  // Scan from farthest to nearest so the nearest candidate is the final assignment.
  always_comb begin
    owner = last_owner;
    valid = 1'b0;
    idx   = 0;
    idx_w = '0;
    for (int i = num_Req; i >= 1; i--) begin
      idx   = (int'(last_owner) + i) % num_Req;
      idx_w = IW'(idx);
      if (req[idx_w]) begin
        owner = idx_w;
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fifo_rd_arbiter.sv
// Async FIFO read-domain controller: round-robin read-port sharing, read pointer, empty flag.
// Define FIFO_RD_BURST_EN for up to max_Burst pops per grant; otherwise one pop per grant.
module fifo_rd_arbiter
  import fifo_rd_arb_pkg::*;
#(
  parameter int address_Size = 3,
  parameter int num_Req      = 4,
  parameter int max_Burst    = 4
) (
  input  logic                    r_Clk,
  input  logic                    r_Rst,
  input  logic [num_Req-1:0]      req,
  input  logic [address_Size:0]   rsync_Wptr,
  input  logic [7:0]              mem_Rdata,
  output logic [address_Size:0]   r_Ptr,
  output logic [address_Size-1:0] r_Addr,
  output logic                    r_En,
  output logic                    r_Empty,
  output logic [num_Req-1:0]      gnt,
  output logic [7:0]              out_Data,
  output logic                    out_Vld,
  output logic [num_Req-1:0]      out_Id
);

  localparam int PW = address_Size + 1;
  localparam int IW = $clog2(num_Req);

  if (num_Req < 2 || num_Req > MAX_REQ || max_Burst < 1 || max_Burst > (1 << address_Size))
  begin : g_cfg_check
    $error("fifo_rd_arbiter: parameter out of range");
  end

  state_t             state;
  logic [PW-1:0]      rbin;
  logic [PW-1:0]      rbin_next;
  logic [PW-1:0]      rgray_next;
  logic [IW-1:0]      last_owner;
  logic [IW-1:0]      cur_owner;
  logic [IW-1:0]      pick_owner;
  logic               pick_vld;
  logic               pop;
  logic [num_Req-1:0] pick_oh;

  rr_pick #(.num_Req(num_Req)) u_pick (
    .req        (req),
    .last_owner (last_owner),
    .owner      (pick_owner),
    .valid      (pick_vld)
  );

  always_comb begin
    pick_oh             = '0;
    pick_oh[pick_owner] = 1'b1;
  end

  assign pop        = (state == SERVE) && |(req & gnt) && !r_Empty;
  assign rbin_next  = rbin + {{(PW-1){1'b0}}, pop};
  assign rgray_next = PW'(bin2gray(32'(rbin_next)));
  assign r_En       = pop;
  assign r_Addr     = rbin[address_Size-1:0];
  assign out_Data   = mem_Rdata;

`ifdef FIFO_RD_BURST_EN
  localparam int BW = $clog2(max_Burst + 1);
  logic [BW-1:0] burst_cnt;
  logic          burst_more;

  // Keep the grant only if this pop is neither the last allowed nor the one that drains the FIFO.
  assign burst_more = pop && (int'(burst_cnt) + 1 < max_Burst) && (rgray_next != rsync_Wptr);
`endif

  always_ff @(posedge r_Clk) begin
    if (!r_Rst) begin
      state      <= IDLE;
      gnt        <= '0;
      rbin       <= '0;
      r_Ptr      <= '0;
      r_Empty    <= 1'b1;
      out_Vld    <= 1'b0;
      out_Id     <= '0;
      last_owner <= IW'(num_Req - 1);
      cur_owner  <= '0;
`ifdef FIFO_RD_BURST_EN
      burst_cnt  <= '0;
`endif
    end else begin
      rbin    <= rbin_next;
      r_Ptr   <= rgray_next;
      r_Empty <= (rgray_next == rsync_Wptr);
      out_Vld <= pop;
      out_Id  <= pop ? gnt : '0;
      case (state)
        IDLE: begin
          if (pick_vld && !r_Empty) begin
            state     <= SERVE;
            gnt       <= pick_oh;
            cur_owner <= pick_owner;
`ifdef FIFO_RD_BURST_EN
            burst_cnt <= '0;
`endif
          end
        end
        SERVE: begin
`ifdef FIFO_RD_BURST_EN
          if (burst_more) begin
            burst_cnt <= burst_cnt + 1'b1;
          end else begin
            state      <= IDLE;
            gnt        <= '0;
            last_owner <= cur_owner;
          end
`else
          state      <= IDLE;
          gnt        <= '0;
          last_owner <= cur_owner;
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_rd_arbiter.sv
// Testbench for fifo_rd_arbiter with address_Size=3, num_Req=4.
module tb_fifo_rd_arbiter;

  localparam int NR = 4;
`ifdef FIFO_RD_BURST_EN
  localparam int MB = 4;
`else
  localparam int MB = 1;
`endif

  logic       r_Clk = 1'b0;
  logic       r_Rst;
  logic [3:0] req;
  logic [3:0] rsync_Wptr;
  logic [7:0] mem_Rdata;
  logic [3:0] r_Ptr;
  logic [2:0] r_Addr;
  logic       r_En;
  logic       r_Empty;
  logic [3:0] gnt;
  logic [7:0] out_Data;
  logic       out_Vld;
  logic [3:0] out_Id;

  fifo_rd_arbiter #(.address_Size(3), .num_Req(NR), .max_Burst(4)) dut (
    .r_Clk      (r_Clk),
    .r_Rst      (r_Rst),
    .req        (req),
    .rsync_Wptr (rsync_Wptr),
    .mem_Rdata  (mem_Rdata),
    .r_Ptr      (r_Ptr),
    .r_Addr     (r_Addr),
    .r_En       (r_En),
    .r_Empty    (r_Empty),
    .gnt        (gnt),
    .out_Data   (out_Data),
    .out_Vld    (out_Vld),
    .out_Id     (out_Id)
  );

  always #5 r_Clk = ~r_Clk;

  // Reference model state: counts and indices as plain integers
  bit         m_serve;
  int         m_owner;
  int         m_last = NR - 1;
  int         m_rbin;
  int         m_bcnt;
  bit         m_empty = 1'b1;
  bit         m_vld;
  bit         m_pop;
  logic [3:0] m_id;
  logic [7:0] m_data;

  logic [3:0] wcnt;
  logic [7:0] mem [8];
  logic [7:0] wq[$];

  int         obs_own[$];
  int         obs_cyc[$];
  int         obs_addr[$];
  logic       pend_en;
  logic [2:0] pend_addr;
  int         cyc_n;
  bit         armed;
  int         n_cmp;
  int         n_err;

  function automatic logic [3:0] gray4(input int b);
    logic [3:0] v;
    v = b[3:0];
    return v ^ (v >> 1);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clr_obs();
    obs_own.delete();
    obs_cyc.delete();
    obs_addr.delete();
  endtask

  task automatic model_edge();
    int  nb;
    bit  pop;
    pop = m_serve && req[m_owner] && !m_empty;
    if (!r_Rst) begin
      m_serve = 1'b0;
      m_owner = 0;
      m_last  = NR - 1;
      m_rbin  = 0;
      m_bcnt  = 0;
      m_empty = 1'b1;
      m_vld   = 1'b0;
      m_id    = '0;
      return;
    end
    nb    = (m_rbin + (pop ? 1 : 0)) % 16;
    m_vld = pop;
    m_id  = pop ? 4'(1 << m_owner) : 4'd0;
    if (pop) m_data = (wq.size() > 0) ? wq.pop_front() : 8'hxx;
    if (!m_serve) begin
      if (req != 4'd0 && !m_empty) begin
        m_serve = 1'b1;
        m_bcnt  = 0;
        for (int k = NR; k >= 1; k--)
          if (req[(m_last + k) % NR]) m_owner = (m_last + k) % NR;
      end
    end else if (pop && m_bcnt + 1 < MB && gray4(nb) != rsync_Wptr) begin
      m_bcnt++;
    end else begin
      m_serve = 1'b0;
      m_last  = m_owner;
    end
    m_rbin  = nb;
    m_empty = (gray4(nb) == rsync_Wptr);
  endtask

  task automatic step(input logic rst_v, input logic [3:0] req_v, input int nwr, input int wp_ovr = -1);
    int own;
    r_Rst = rst_v;
    req   = req_v;
    if (!rst_v) begin
      wcnt = '0;
      wq.delete();
    end else begin
      for (int i = 0; i < nwr; i++) begin
        if ((int'(wcnt) - m_rbin + 16) % 16 < 8) begin
          mem[wcnt[2:0]] = 8'($urandom);
          wq.push_back(mem[wcnt[2:0]]);
          wcnt = wcnt + 4'd1;
        end
      end
    end
    rsync_Wptr = (wp_ovr >= 0) ? 4'(wp_ovr) : gray4(int'(wcnt));
    #1;
    m_pop = m_serve && req[m_owner] && !m_empty;
    if (armed) begin
      chk("r_En", 32'(r_En), 32'(m_pop));
      chk("r_Addr", 32'(r_Addr), 32'(m_rbin % 8));
    end
    pend_en   = r_En;
    pend_addr = r_Addr;
    if (r_En === 1'b1) begin
      own = -1;
      for (int k = 0; k < NR; k++) if (gnt[k]) own = k;
      obs_own.push_back(own);
      obs_cyc.push_back(cyc_n);
      obs_addr.push_back(int'(r_Addr));
    end
    @(posedge r_Clk);
    if (pend_en === 1'b1) mem_Rdata = mem[pend_addr];
    model_edge();
    armed = 1'b1;
    #1;
    chk("r_Ptr", 32'(r_Ptr), 32'(gray4(m_rbin)));
    chk("r_Empty", 32'(r_Empty), 32'(m_empty));
    chk("gnt", 32'(gnt), m_serve ? (32'd1 << m_owner) : 32'd0);
    chk("out_Vld", 32'(out_Vld), 32'(m_vld));
    if (m_vld) begin
      chk("out_Id", 32'(out_Id), 32'(m_id));
      chk("out_Data", 32'(out_Data), 32'(m_data));
    end
    cyc_n++;
  endtask

  initial begin
    r_Rst      = 1'b0;
    req        = '0;
    rsync_Wptr = '0;
    mem_Rdata  = '0;
    wcnt       = '0;
    armed      = 1'b0;
    n_cmp      = 0;
    n_err      = 0;
    cyc_n      = 0;

    // 1: reset with requests pending and a non-matching write pointer
    step(1'b0, 4'hF, 0, 3);
    step(1'b0, 4'hF, 0, 3);
    chk("t1_r_Empty", 32'(r_Empty), 32'd1);
    chk("t1_gnt", 32'(gnt), 32'd0);
    chk("t1_r_Ptr", 32'(r_Ptr), 32'd0);
    chk("t1_r_En", 32'(r_En), 32'd0);
    chk("t1_out_Vld", 32'(out_Vld), 32'd0);
    step(1'b1, 4'h0, 0);
    step(1'b1, 4'h0, 0);

    // 2: single consumer, three entries
    clr_obs();
    step(1'b1, 4'b0001, 3);
    repeat (10) step(1'b1, 4'b0001, 0);
    chk("t2_pops", 32'(obs_own.size()), 32'd3);
    for (int k = 0; k < 3 && k < obs_addr.size(); k++) begin
      chk("t2_addr", 32'(obs_addr[k]), 32'(k));
      chk("t2_owner", 32'(obs_own[k]), 32'd0);
    end
    chk("t2_r_Ptr", 32'(r_Ptr), 32'b0010);
    chk("t2_r_Empty", 32'(r_Empty), 32'd1);

    // 3: all four requesting, eight entries
    step(1'b0, 4'h0, 0);
    step(1'b1, 4'h0, 0);
    clr_obs();
    step(1'b1, 4'hF, 8);
    repeat (24) step(1'b1, 4'hF, 0);
    chk("t3_pops", 32'(obs_own.size()), 32'd8);
    for (int k = 0; k < 8 && k < obs_own.size(); k++)
      chk("t3_owner", 32'(obs_own[k]), 32'((k / MB) % NR));
    for (int k = 1; k < 8 && k < obs_cyc.size(); k++)
      chk("t3_gap", 32'(obs_cyc[k] - obs_cyc[k-1]), (k % MB == 0) ? 32'd2 : 32'd1);
    chk("t3_r_Empty", 32'(r_Empty), 32'd1);

    // 4: continue across both pointer wraps
    clr_obs();
    step(1'b1, 4'b0001, 7);
    repeat (20) step(1'b1, 4'b0001, 0);
    step(1'b1, 4'b0001, 2);
    repeat (8) step(1'b1, 4'b0001, 0);
    chk("t4_pops", 32'(obs_own.size()), 32'd9);
    if (obs_addr.size() >= 9) begin
      chk("t4_addr7", 32'(obs_addr[7]), 32'd7);
      chk("t4_addr0", 32'(obs_addr[8]), 32'd0);
    end
    chk("t4_r_Ptr", 32'(r_Ptr), 32'b0001);
    chk("t4_r_Empty", 32'(r_Empty), 32'd1);

    // 6a: requester 0 drops after two pops
    step(1'b0, 4'h0, 0);
    step(1'b1, 4'h0, 0);
    clr_obs();
    step(1'b1, 4'b0011, 8);
    for (int i = 0; i < 30 && obs_own.size() < 2; i++) step(1'b1, 4'b0011, 0);
    chk("t6_two_pops", 32'(obs_own.size()), 32'd2);
    repeat (10) step(1'b1, 4'b0010, 0);
    chk("t6_next_owner", (obs_own.size() >= 3) ? 32'(obs_own[2]) : 32'hFFFF_FFFF, 32'd1);

    // 6b: reset while a grant is active
    step(1'b1, 4'hF, 4);
    for (int i = 0; i < 20 && gnt == 4'd0; i++) step(1'b1, 4'hF, 0);
    chk("t6_gnt_seen", 32'(gnt != 4'd0), 32'd1);
    step(1'b0, 4'hF, 0);
    chk("t6_rst_r_Ptr", 32'(r_Ptr), 32'd0);
    chk("t6_rst_r_Addr", 32'(r_Addr), 32'd0);
    chk("t6_rst_gnt", 32'(gnt), 32'd0);
    chk("t6_rst_r_Empty", 32'(r_Empty), 32'd1);
    chk("t6_rst_out_Vld", 32'(out_Vld), 32'd0);
    chk("t6_rst_out_Id", 32'(out_Id), 32'd0);
    step(1'b1, 4'h0, 0);

    // random traffic with occasional resets
    repeat (400) begin
      step(($urandom_range(0, 59) != 0) ? 1'b1 : 1'b0,
           4'($urandom_range(0, 15)),
           ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
